// File: rtl/wb_cmd_master.sv
// wb_cmd_master
// Wishbone B4 pipelined initiator. Turns a simple command (single write or
// incrementing read burst of 1..16 beats) into bus cycles, honours slave
// stall, and returns one registered response per acknowledged beat.
//
// Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN
//   defined   -> watchdog counter and ABORT state are built; a hung cycle is
//                aborted with a single rsp_err/rsp_last pulse.
//   undefined -> no watchdog; BUS waits indefinitely and rsp_err stays 0.
module wb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [3:0]          cmd_len,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_last,
    output logic                busy,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_we,
    output logic [ADDR_W-1:0]   o_wb_addr,
    output logic [DATA_W-1:0]   o_wb_data,
    output logic [DATA_W/8-1:0] o_wb_sel,
    input  logic                i_wb_ack,
    input  logic                i_wb_stall,
    input  logic [DATA_W-1:0]   i_wb_data
);

    localparam int SEL_W = DATA_W / 8;
    // Byte address increment between consecutive beats.
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(SEL_W);

    // Reject parameter combinations the datapath cannot represent.
    if (((DATA_W % 8) != 0) || (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_param_check
        $error("wb_cmd_master: DATA_W must be a multiple of 8 and TIMEOUT in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    // Latched command and beat bookkeeping.
    logic              we_r,    we_s;
    logic [ADDR_W-1:0] addr_r,  addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic [4:0]        beats_r,  beats_s;
    logic [4:0]        issued_r, issued_s;
    logic [4:0]        acked_r,  acked_s;

    // Registered bus / status outputs.
    logic cyc_r, cyc_s;
    logic stb_r, stb_s;
    logic busy_r, busy_s;
    logic cmd_ready_r, cmd_ready_s;

    // Registered response outputs.
    logic              rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
    logic              rsp_err_r,   rsp_err_s;
    logic              rsp_last_r,  rsp_last_s;

    // Per-cycle bus events.
    logic issue_s;
    logic ack_s;
    logic timeout_s;

    // Bus events: a beat issues on stb without stall; only acks for
    // outstanding beats count, everything else is a spurious ack.
    always_comb begin
        issue_s = (state_r == ST_BUS) && stb_r && !i_wb_stall;
        ack_s   = (state_r == ST_BUS) && i_wb_ack && (acked_r < issued_r);
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);

    logic [15:0] wdog_r;
    logic [15:0] wdog_s;

    // Watchdog next value: restarts on BUS entry and on any bus progress,
    // otherwise counts idle BUS cycles.
    always_comb begin
        wdog_s = wdog_r;
        if (state_r == ST_BUS) begin
            if (issue_s || ack_s) begin
                wdog_s = 16'd0;
            end else begin
                wdog_s = wdog_r + 16'd1;
            end
        end else begin
            wdog_s = 16'd0;
        end
    end

    // Abort request: limit reached and nothing happened this cycle (an ack
    // in the same cycle takes precedence).
    always_comb begin
        timeout_s = (state_r == ST_BUS) && (wdog_r == WDOG_LIMIT) && !issue_s && !ack_s;
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_r <= 16'd0;
        end else begin
            wdog_r <= wdog_s;
        end
    end
`else
    // Without the watchdog a hung cycle is never aborted.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // Next-state, command latch, beat counters and response generation.
    always_comb begin
        state_s     = state_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        beats_s     = beats_r;
        issued_s    = issued_r;
        acked_s     = acked_r;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = {DATA_W{1'b0}};
        rsp_err_s   = 1'b0;
        rsp_last_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_s     = cmd_we;
                    addr_s   = cmd_addr;
                    wdata_s  = cmd_we ? cmd_wdata : {DATA_W{1'b0}};
                    beats_s  = cmd_we ? 5'd1 : ({1'b0, cmd_len} + 5'd1);
                    issued_s = 5'd0;
                    acked_s  = 5'd0;
                    state_s  = ST_BUS;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_BUS: begin
                if (issue_s) begin
                    issued_s = issued_r + 5'd1;
                    addr_s   = addr_r + ADDR_STEP;
                end else begin
                    issued_s = issued_r;
                end

                if (ack_s) begin
                    acked_s     = acked_r + 5'd1;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = we_r ? {DATA_W{1'b0}} : i_wb_data;
                    rsp_last_s  = ((acked_r + 5'd1) == beats_r);
                    if ((acked_r + 5'd1) == beats_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BUS;
                    end
                end else if (timeout_s) begin
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    rsp_last_s  = 1'b1;
                    state_s     = ST_ABORT;
                end else begin
                    state_s = ST_BUS;
                end
            end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
            ST_ABORT: begin
                state_s = ST_IDLE;
            end
`endif

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register cleanly.
        cyc_s       = (state_s == ST_BUS);
        stb_s       = (state_s == ST_BUS) && (issued_s < beats_s);
        busy_s      = (state_s != ST_IDLE);
        cmd_ready_s = (state_s == ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, bus control and response registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            beats_r     <= 5'd0;
            issued_r    <= 5'd0;
            acked_r     <= 5'd0;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            rsp_last_r  <= 1'b0;
        end else begin
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            beats_r     <= beats_s;
            issued_r    <= issued_s;
            acked_r     <= acked_s;
            cyc_r       <= cyc_s;
            stb_r       <= stb_s;
            busy_r      <= busy_s;
            cmd_ready_r <= cmd_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            rsp_last_r  <= rsp_last_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign o_wb_cyc  = cyc_r;
    assign o_wb_stb  = stb_r;
    assign o_wb_we   = we_r;
    assign o_wb_addr = addr_r;
    assign o_wb_data = wdata_r;
    assign o_wb_sel  = {SEL_W{1'b1}};
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_last  = rsp_last_r;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: behavioural Wishbone slave with random stall,
// ack latency and spurious acks, plus a transaction-level expectation model
// (expected bus beats and responses per accepted command).
`timescale 1ns/1ps
module tb_wb_cmd_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_len;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, rsp_last, busy;
    logic [31:0] rsp_rdata;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack, i_wb_stall;
    logic [31:0] i_wb_data;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_len(cmd_len), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_last(rsp_last), .busy(busy),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
    );

    typedef struct { logic [31:0] rdata; logic last; } rsp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } iss_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    rsp_t  exp_rsp_q[$];
    iss_t  exp_iss_q[$];
    pend_t pend_q[$];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int lat_min = 1, lat_max = 1, stall_pct = 0, spur_pct = 0;
    bit no_ack = 1'b0, force_ack = 1'b0, abort_mode = 1'b0;
    int stall_beat = -1, stall_len = 0, stall_done = 0, beat_idx = 0, consec_stall = 0;
    int abort_seen = 0, abort_cyc = 0, issue_cyc = 0;
    int stb_cycles = 0, acc_cyc = 0, last_cyc = 0, rsp_total = 0;

    // Slave memory contents: a fixed scramble of the address.
    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic set_slave(input int lmin, input int lmax, input int spct, input int upct);
        lat_min = lmin; lat_max = lmax; stall_pct = spct; spur_pct = upct;
        stall_beat = -1; stall_len = 0;
    endtask

    task automatic clear_model();
        exp_rsp_q.delete(); exp_iss_q.delete(); pend_q.delete();
    endtask

    // Expected beats and responses for the command being accepted.
    task automatic model_accept();
        int n;
        logic [31:0] a;
        n = cmd_we ? 1 : int'(cmd_len) + 1;
        for (int i = 0; i < n; i++) begin
            a = cmd_addr + 32'(4 * i);
            exp_iss_q.push_back('{a, cmd_we, cmd_we ? cmd_wdata : 32'h0});
            exp_rsp_q.push_back('{cmd_we ? 32'h0 : slave_data(a), (i == n - 1)});
        end
        acc_cyc = cyc_n; beat_idx = 0; stall_done = 0;
    endtask

    // One clock: accept bookkeeping, response monitor, slave behaviour.
    task automatic step();
        bit acc, stall, issue_now, ack_now;
        rsp_t r;
        iss_t is;
        pend_t p;
        acc = (cmd_valid === 1'b1) && (cmd_ready === 1'b1) && (reset_n === 1'b1);
        if (acc) model_accept();
        @(posedge clk); #1;
        cyc_n++;

        checks++;
        if (cmd_ready !== ~busy) begin
            errors++; $display("FAIL ready_busy cmd_ready=%b busy=%b required complementary", cmd_ready, busy);
        end

        if (rsp_valid === 1'b1) begin
            rsp_total++;
            if (abort_mode) begin
                checks++;
                if (rsp_err !== 1'b1 || rsp_last !== 1'b1 || rsp_rdata !== 32'h0 || o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_rsp err=%b last=%b rdata=%h cyc=%b stb=%b required 1 1 00000000 0 0",
                             rsp_err, rsp_last, rsp_rdata, o_wb_cyc, o_wb_stb);
                end
                abort_seen++; abort_cyc = cyc_n;
            end else if (exp_rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp rdata=%h last=%b err=%b required no response", rsp_rdata, rsp_last, rsp_err);
            end else begin
                r = exp_rsp_q.pop_front();
                checks++;
                if (rsp_rdata !== r.rdata || rsp_last !== r.last || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp rdata=%h last=%b err=%b required rdata=%h last=%b err=0",
                             rsp_rdata, rsp_last, rsp_err, r.rdata, r.last);
                end
                checks++;
                if (r.last) begin
                    last_cyc = cyc_n;
                    if (o_wb_cyc !== 1'b0 || cmd_ready !== 1'b1) begin
                        errors++; $display("FAIL end_of_cmd cyc=%b cmd_ready=%b required 0 1", o_wb_cyc, cmd_ready);
                    end
                end else if (o_wb_cyc !== 1'b1) begin
                    errors++; $display("FAIL mid_cmd_cyc cyc=%b required 1", o_wb_cyc);
                end
            end
        end

        if (o_wb_stb === 1'b1) stb_cycles++;
        stall = 1'b0;
        if (o_wb_stb === 1'b1) begin
            if (beat_idx == stall_beat && stall_done < stall_len) begin
                stall = 1'b1; stall_done++;
            end else if (stall_pct > 0 && consec_stall < 3 && $urandom_range(99) < stall_pct) begin
                stall = 1'b1;
            end
        end
        consec_stall = stall ? consec_stall + 1 : 0;
        issue_now = (o_wb_stb === 1'b1) && !stall && (reset_n === 1'b1);

        ack_now = 1'b0;
        if (!no_ack && pend_q.size() > 0 && pend_q[0].due <= cyc_n) begin
            p = pend_q.pop_front();
            ack_now = 1'b1;
            i_wb_data = slave_data(p.addr);
        end else begin
            i_wb_data = $urandom();
            if (force_ack || (spur_pct > 0 && pend_q.size() == 0 && $urandom_range(99) < spur_pct)) ack_now = 1'b1;
        end
        i_wb_ack = ack_now;
        i_wb_stall = stall;

        if (issue_now) begin
            beat_idx++; issue_cyc = cyc_n;
            checks++;
            if (exp_iss_q.size() == 0) begin
                errors++; $display("FAIL unexpected_issue addr=%h required no beat", o_wb_addr);
            end else begin
                is = exp_iss_q.pop_front();
                if (o_wb_addr !== is.addr || o_wb_we !== is.we || o_wb_data !== is.data || o_wb_cyc !== 1'b1 || o_wb_sel !== 4'hF) begin
                    errors++;
                    $display("FAIL issue addr=%h we=%b data=%h cyc=%b sel=%h required addr=%h we=%b data=%h cyc=1 sel=f",
                             o_wb_addr, o_wb_we, o_wb_data, o_wb_cyc, o_wb_sel, is.addr, is.we, is.data);
                end
            end
            pend_q.push_back('{o_wb_addr, cyc_n + int'($urandom_range(lat_max, lat_min))});
        end
    endtask

    task automatic send_cmd(input logic we, input logic [3:0] len, input logic [31:0] addr, input logic [31:0] wdata);
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 200) begin step(); k++; end
        if (cmd_ready !== 1'b1) begin
            checks++; errors++; $display("FAIL cmd_ready_wait cmd_ready=%b required 1", cmd_ready);
        end
        cmd_we = we; cmd_len = len; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0; cmd_addr = $urandom(); cmd_wdata = $urandom(); cmd_len = 4'($urandom());
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((exp_rsp_q.size() != 0 || busy !== 1'b0) && k < budget) begin step(); k++; end
        checks++;
        if (exp_rsp_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_done pending=%0d busy=%b required 0 0", name, exp_rsp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_wb_we !== 1'b0 ||
            o_wb_addr !== 32'h0 || o_wb_data !== 32'h0 || o_wb_sel !== 4'hF || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_last !== 1'b0) begin
            errors++;
            $display("FAIL reset ready=%b busy=%b cyc=%b stb=%b we=%b addr=%h data=%h sel=%h rv=%b rd=%h err=%b last=%b required 1 0 0 0 0 0 0 f 0 0 0 0",
                     cmd_ready, busy, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
                     rsp_valid, rsp_rdata, rsp_err, rsp_last);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        set_slave(1, 1, 0, 0); stb_cycles = 0;
        send_cmd(1'b1, 4'h7, 32'h3000_0004, 32'hA5A5_0F0F);
        wait_done("single_write", 50);
        checks++;
        if (stb_cycles != 1) begin errors++; $display("FAIL write_stb_cycles got=%0d required 1", stb_cycles); end
        checks++;
        if (last_cyc - acc_cyc != 3) begin errors++; $display("FAIL write_latency got=%0d required 3", last_cyc - acc_cyc); end
    endtask

    task automatic test_four_beat();
        set_slave(1, 1, 0, 0); stb_cycles = 0;
        send_cmd(1'b0, 4'd3, 32'h3000_0040, 32'h0);
        wait_done("four_beat", 50);
        checks++;
        if (stb_cycles != 4) begin errors++; $display("FAIL burst4_stb_cycles got=%0d required 4", stb_cycles); end
        checks++;
        if (last_cyc - acc_cyc != 6) begin errors++; $display("FAIL burst4_latency got=%0d required 6", last_cyc - acc_cyc); end
    endtask

    task automatic test_burst_stall();
        set_slave(1, 1, 0, 0); stall_beat = 1; stall_len = 2; stb_cycles = 0;
        send_cmd(1'b0, 4'd3, 32'h3000_0000, 32'h0);
        wait_done("burst_stall", 60);
        checks++;
        if (stb_cycles != 6) begin errors++; $display("FAIL stall_stb_cycles got=%0d required 6", stb_cycles); end
        set_slave(1, 1, 0, 0);
    endtask

    task automatic test_addr_wrap();
        set_slave(1, 2, 0, 0);
        send_cmd(1'b0, 4'd1, 32'hFFFF_FFFC, 32'h0);
        wait_done("addr_wrap", 50);
    endtask

    task automatic test_idle_ack();
        set_slave(1, 1, 0, 0);
        force_ack = 1'b1; step(); force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_ack rsp_valid=%b required 0", rsp_valid); end
        end
    endtask

    task automatic test_midburst_reset();
        int k = 0;
        set_slave(1, 1, 0, 0);
        send_cmd(1'b0, 4'd3, 32'h3000_0100, 32'h0);
        while (beat_idx < 2 && k < 20) begin step(); k++; end
        reset_n = 1'b0;
        step();
        checks++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midburst_reset cyc=%b stb=%b rsp_valid=%b required 0 0 0", o_wb_cyc, o_wb_stb, rsp_valid);
        end
        reset_n = 1'b1;
        clear_model();
        step();
        send_cmd(1'b0, 4'd3, 32'h3000_0200, 32'h0);
        wait_done("after_reset", 50);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            set_slave(1, int'($urandom_range(3, 1)), int'($urandom_range(40)), 20);
            a = {$urandom()} & 32'hFFFF_FFFC;
            if ($urandom_range(3) == 0) a = 32'hFFFF_FFC0 | ({$urandom()} & 32'h0000_003C);
            send_cmd($urandom_range(2) == 0, 4'($urandom()), a, $urandom());
            wait_done("random", 200);
        end
        set_slave(1, 1, 0, 0);
    endtask

    task automatic test_timeout();
        int k = 0;
        set_slave(1, 1, 0, 0);
        no_ack = 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        abort_mode = 1'b1; abort_seen = 0;
        send_cmd(1'b1, 4'h0, 32'h3000_0008, 32'h1234_5678);
        while (abort_seen == 0 && k < 100) begin step(); k++; end
        checks++;
        if (abort_seen != 1 || abort_cyc - issue_cyc != TIMEOUT + 2) begin
            errors++; $display("FAIL timeout_abort seen=%0d delay=%0d required 1 %0d", abort_seen, abort_cyc - issue_cyc, TIMEOUT + 2);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || o_wb_cyc !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL after_abort ready=%b busy=%b cyc=%b rsp_valid=%b required 1 0 0 0", cmd_ready, busy, o_wb_cyc, rsp_valid);
        end
        repeat (3) step();
        checks++;
        if (abort_seen != 1) begin errors++; $display("FAIL abort_pulses got=%0d required 1", abort_seen); end
        abort_mode = 1'b0;
        clear_model();
`else
        rsp_total = 0;
        send_cmd(1'b1, 4'h0, 32'h3000_0008, 32'h1234_5678);
        exp_rsp_q.delete();
        for (int i = 0; i < 1000; i++) begin
            step();
            if (busy !== 1'b1) k++;
        end
        checks++;
        if (k != 0 || rsp_total != 0) begin
            errors++; $display("FAIL hang_no_watchdog busy_low=%0d rsp=%0d required 0 0", k, rsp_total);
        end
        reset_n = 1'b0; step(); reset_n = 1'b1;
        clear_model();
        step();
`endif
        no_ack = 1'b0;
        send_cmd(1'b0, 4'd2, 32'h3000_0300, 32'h0);
        wait_done("after_timeout", 50);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_len = 4'h0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0;
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 32'h0;
        test_reset();
        test_single_write();
        test_four_beat();
        test_burst_stall();
        test_addr_wrap();
        test_idle_ack();
        test_midburst_reset();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit time=%0t required finish before limit", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
